// File: rtl/board_access_arbiter.sv
// Single-port board memory arbiter: drop writer, victory checker and display scanner
// share one 8x8 store through req/gnt handshakes with checker locking and display promotion.
module board_access_arbiter #(
    parameter int ROW_BITS  = 3,
    parameter int COL_BITS  = 3,
    parameter int DATA_BITS = 2,
    parameter int MAX_WAIT  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_req,
    input  logic [ROW_BITS-1:0]  wr_row,
    input  logic [COL_BITS-1:0]  wr_col,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 wr_gnt,
    input  logic                 chk_req,
    input  logic                 chk_lock,
    input  logic [ROW_BITS-1:0]  chk_row,
    input  logic [COL_BITS-1:0]  chk_col,
    output logic                 chk_gnt,
    output logic                 chk_valid,
    output logic [DATA_BITS-1:0] chk_data,
    input  logic                 dsp_req,
    input  logic [ROW_BITS-1:0]  dsp_row,
    input  logic [COL_BITS-1:0]  dsp_col,
    output logic                 dsp_gnt,
    output logic                 dsp_valid,
    output logic [DATA_BITS-1:0] dsp_data,
    output logic [ROW_BITS-1:0]  mem_row,
    output logic [COL_BITS-1:0]  mem_col,
    output logic [DATA_BITS-1:0] mem_wdata,
    output logic                 mem_write,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic                 locked,
    output logic [1:0]           owner
);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t     state_reg;
    logic [3:0] wait_cnt_reg;
    logic       chk_valid_reg;
    logic       dsp_valid_reg;
    logic       promote;

    // Promotion only matters while unlocked; a lock always belongs to the checker.
    assign promote = (state_reg == ST_UNLOCKED) && (wait_cnt_reg >= 4'(MAX_WAIT));

    always_comb begin
        wr_gnt  = 1'b0;
        chk_gnt = 1'b0;
        dsp_gnt = 1'b0;
        if (rst_n) begin
            if (state_reg == ST_LOCKED) begin
                chk_gnt = chk_req;
            end else if (promote && dsp_req) begin
                dsp_gnt = 1'b1;
            end else if (wr_req) begin
                wr_gnt = 1'b1;
            end else if (chk_req) begin
                chk_gnt = 1'b1;
            end else if (dsp_req) begin
                dsp_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_row   = '0;
        mem_col   = '0;
        mem_wdata = '0;
        if (wr_gnt) begin
            mem_row   = wr_row;
            mem_col   = wr_col;
            mem_wdata = wr_data;
        end else if (chk_gnt) begin
            mem_row = chk_row;
            mem_col = chk_col;
        end else if (dsp_gnt) begin
            mem_row = dsp_row;
            mem_col = dsp_col;
        end
    end

    assign mem_write = wr_gnt;
    assign owner     = {chk_gnt | dsp_gnt, wr_gnt | dsp_gnt};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_UNLOCKED;
            wait_cnt_reg  <= 4'd0;
            chk_valid_reg <= 1'b0;
            dsp_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_UNLOCKED: begin
                    if (chk_gnt && chk_lock) begin
                        state_reg <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    // Checker abandoning the burst, or its last access, hands the store back.
                    if (!chk_req || (chk_gnt && !chk_lock)) begin
                        state_reg <= ST_UNLOCKED;
                    end
                end
                default: state_reg <= ST_UNLOCKED;
            endcase

            if (dsp_req && !dsp_gnt) begin
                wait_cnt_reg <= (wait_cnt_reg == 4'd15) ? 4'd15 : wait_cnt_reg + 4'd1;
            end else begin
                wait_cnt_reg <= 4'd0;
            end

            chk_valid_reg <= chk_gnt;
            dsp_valid_reg <= dsp_gnt;
        end
    end

    // Gating with rst_n drops a read return that would land in the reset cycle.
    assign locked    = rst_n && (state_reg == ST_LOCKED);
    assign chk_valid = rst_n && chk_valid_reg;
    assign dsp_valid = rst_n && dsp_valid_reg;
    assign chk_data  = chk_valid ? mem_rdata : '0;
    assign dsp_data  = dsp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_board_access_arbiter.sv
// Randomized scoreboard bench for board_access_arbiter with a priority-list reference model
// and a behavioural registered-read board memory.
module tb_board_access_arbiter;

    localparam int RB     = 3;
    localparam int CB     = 3;
    localparam int DB     = 2;
    localparam int MW     = 4;
    localparam int N_CYC  = 3000;
    localparam int N_TAIL = 40;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_req, chk_req, chk_lock, dsp_req;
    logic [RB-1:0] wr_row, chk_row, dsp_row;
    logic [CB-1:0] wr_col, chk_col, dsp_col;
    logic [DB-1:0] wr_data;
    logic          wr_gnt, chk_gnt, dsp_gnt, chk_valid, dsp_valid;
    logic [DB-1:0] chk_data, dsp_data;
    logic [RB-1:0] mem_row;
    logic [CB-1:0] mem_col;
    logic [DB-1:0] mem_wdata, mem_rdata;
    logic          mem_write, locked;
    logic [1:0]    owner;

    always #5 clk = ~clk;

    board_access_arbiter #(
        .ROW_BITS(RB), .COL_BITS(CB), .DATA_BITS(DB), .MAX_WAIT(MW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .chk_req(chk_req), .chk_lock(chk_lock), .chk_row(chk_row), .chk_col(chk_col),
        .chk_gnt(chk_gnt), .chk_valid(chk_valid), .chk_data(chk_data),
        .dsp_req(dsp_req), .dsp_row(dsp_row), .dsp_col(dsp_col),
        .dsp_gnt(dsp_gnt), .dsp_valid(dsp_valid), .dsp_data(dsp_data),
        .mem_row(mem_row), .mem_col(mem_col), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .locked(locked), .owner(owner)
    );

    // Board store: write on strobe, registered read of the presented address.
    logic [DB-1:0] board_mem [64];
    initial begin
        for (int i = 0; i < 64; i++) board_mem[i] = DB'(i % 3);
        forever begin
            @(posedge clk);
            if (mem_write) board_mem[{mem_row, mem_col}] <= mem_wdata;
            mem_rdata <= board_mem[{mem_row, mem_col}];
        end
    end

    typedef struct {
        logic [1:0] owner;
        logic [2:0] gnts;
        logic [5:0] addr;
        logic [1:0] wdata;
        logic       write;
        logic       locked;
    } exp_t;

    typedef struct {
        int         due;
        logic [1:0] data;
    } rd_t;

    exp_t exp_q [$];
    rd_t  chk_q [$];
    rd_t  dsp_q [$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: one expected record per cycle, read returns matched by due cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic       ev_chk, ev_dsp;
            logic [1:0] ed_chk, ed_dsp;
            e = exp_q.pop_front();
            check("owner",     32'(owner), 32'(e.owner));
            check("grants",    32'({dsp_gnt, chk_gnt, wr_gnt}), 32'(e.gnts));
            check("mem_addr",  32'({mem_row, mem_col}), 32'(e.addr));
            check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
            check("mem_write", 32'(mem_write), 32'(e.write));
            check("locked",    32'(locked), 32'(e.locked));

            ev_chk = (chk_q.size() > 0) && (chk_q[0].due == cyc);
            ed_chk = 2'b00;
            if (ev_chk) begin
                ed_chk = chk_q[0].data;
                void'(chk_q.pop_front());
            end
            ev_dsp = (dsp_q.size() > 0) && (dsp_q[0].due == cyc);
            ed_dsp = 2'b00;
            if (ev_dsp) begin
                ed_dsp = dsp_q[0].data;
                void'(dsp_q.pop_front());
            end
            check("chk_valid", 32'(chk_valid), 32'(ev_chk));
            check("chk_data",  32'(chk_data),  32'(ed_chk));
            check("dsp_valid", 32'(dsp_valid), 32'(ev_dsp));
            check("dsp_data",  32'(dsp_data),  32'(ed_dsp));
            if (ev_chk) $display("cyc=%0d chk read data=%0d", cyc, ed_chk);
            if (ev_dsp) $display("cyc=%0d dsp read data=%0d", cyc, ed_dsp);
        end
    end

    // Stimulus and reference model.
    initial begin
        logic [1:0] shadow [64];
        logic       wr_pend, chk_pend, dsp_pend;
        logic       m_locked;
        int         m_wait;
        logic       rst_now;
        int         g;
        int         order [3];
        logic       req_v [4];
        exp_t       e;

        for (int i = 0; i < 64; i++) shadow[i] = 2'(i % 3);
        wr_pend = 1'b0; chk_pend = 1'b0; dsp_pend = 1'b0;
        m_locked = 1'b0; m_wait = 0;
        rst_n = 1'b0;
        wr_req = 1'b0; chk_req = 1'b0; chk_lock = 1'b0; dsp_req = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0;
        chk_row = '0; chk_col = '0; dsp_row = '0; dsp_col = '0;

        for (int n = 0; n < N_CYC + N_TAIL; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            rst_now = (cyc <= 2) || ((n < N_CYC) && ($urandom_range(0, 99) < 2));
            rst_n   = !rst_now;

            if (n < N_CYC) begin
                if (!wr_pend && $urandom_range(0, 99) < 35) begin
                    wr_pend = 1'b1;
                    wr_row  = RB'($urandom_range(0, 7));
                    wr_col  = CB'($urandom_range(0, 7));
                    wr_data = DB'($urandom_range(1, 2));
                end
                if (!chk_pend && $urandom_range(0, 99) < (m_locked ? 85 : 40)) begin
                    chk_pend = 1'b1;
                    chk_row  = RB'($urandom_range(0, 7));
                    chk_col  = CB'($urandom_range(0, 7));
                    chk_lock = ($urandom_range(0, 99) < 70);
                end
                if (!dsp_pend && $urandom_range(0, 99) < 50) begin
                    dsp_pend = 1'b1;
                    dsp_row  = RB'($urandom_range(0, 7));
                    dsp_col  = CB'($urandom_range(0, 7));
                end
            end
            wr_req  = wr_pend;
            chk_req = chk_pend;
            dsp_req = dsp_pend;

            // Pick the first requester in the current priority order (1 wr, 2 chk, 3 dsp).
            req_v[0] = 1'b0; req_v[1] = wr_pend; req_v[2] = chk_pend; req_v[3] = dsp_pend;
            g = 0;
            if (!rst_now) begin
                if (m_locked) begin
                    if (chk_pend) g = 2;
                end else begin
                    if (m_wait >= MW) order = '{3, 1, 2};
                    else              order = '{1, 2, 3};
                    for (int i = 0; i < 3; i++) begin
                        if (g == 0 && req_v[order[i]]) g = order[i];
                    end
                end
            end

            e.owner  = 2'(g);
            e.gnts   = 3'b000;
            e.addr   = 6'd0;
            e.wdata  = 2'b00;
            e.write  = (g == 1);
            e.locked = !rst_now && m_locked;
            if (g == 1) begin
                e.gnts = 3'b001; e.addr = {wr_row, wr_col}; e.wdata = wr_data;
            end else if (g == 2) begin
                e.gnts = 3'b010; e.addr = {chk_row, chk_col};
            end else if (g == 3) begin
                e.gnts = 3'b100; e.addr = {dsp_row, dsp_col};
            end
            exp_q.push_back(e);

            if (rst_now) begin
                chk_q.delete();
                dsp_q.delete();
            end
            if (g == 2) chk_q.push_back('{cyc + 1, shadow[{chk_row, chk_col}]});
            if (g == 3) dsp_q.push_back('{cyc + 1, shadow[{dsp_row, dsp_col}]});
            if (g == 1) begin
                shadow[{wr_row, wr_col}] = wr_data;
                $display("cyc=%0d write (%0d,%0d)=%0d", cyc, wr_row, wr_col, wr_data);
            end

            if (rst_now) begin
                m_locked = 1'b0;
                m_wait   = 0;
            end else begin
                if (m_locked) begin
                    if (!chk_pend || (g == 2 && !chk_lock)) m_locked = 1'b0;
                end else if (g == 2 && chk_lock) begin
                    m_locked = 1'b1;
                end
                if (dsp_pend && g != 3) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
                else                    m_wait = 0;
            end

            if (g == 1) wr_pend  = 1'b0;
            if (g == 2) chk_pend = 1'b0;
            if (g == 3) dsp_pend = 1'b0;
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
